edid_block_checker: RTL and testbench
=====================================

Name: edid_block_checker

Overview:
Sits directly downstream of the I2C master that reads the HDMI DDC EEPROM at address 0x50. Consumes the received byte stream one byte per strobe and stores the block for LED/debug read-back. Checks the fixed 8-byte EDID header and the mod-256 checksum, and latches key identity fields. Runs on the I2C bit clock domain, so no CDC is needed at its input.

Parameters:
BLOCK_BYTES, 128, bytes per EDID block; must be a power of two and at least 16.
IDX_W, $clog2(BLOCK_BYTES), byte index width.

Ports:
clk  in  1  clock; same clock as the I2C master.
rst  in  1  reset, asynchronous assert, active-low.
start  in  1  one-cycle pulse; begins a new block capture.
byte_valid  in  1  one-cycle strobe; byte_data is valid this cycle.
byte_data  in  8  received byte.
rd_addr  in  IDX_W  read-back address.
rd_data  out  8  stored byte at rd_addr; 1-cycle latency.
busy  out  1  capture in progress.
done  out  1  high in DONE; cleared by the next start.
header_ok  out  1  all 8 header bytes matched; valid when done.
checksum_ok  out  1  sum of all BLOCK_BYTES bytes mod 256 equals 0; valid when done.
overflow  out  1  sticky; byte_valid seen in DONE or ERROR state.
mfg_id  out  16  bytes 8..9, big-endian ({byte8, byte9}).
product_code  out  16  bytes 10..11, little-endian ({byte11, byte10}).
edid_ver  out  16  {byte18, byte19}.
ext_count  out  8  byte 126.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; byte index = 0; running sum = 0.
  - All outputs 0, including rd_data; RAM contents are don't-care.
- States: IDLE, HEADER, BODY, DONE, ERROR.
  - IDLE -> HEADER on start.
  - HEADER: bytes 0..7. Each byte is compared against 00 FF FF FF FF FF FF 00.
    - Any mismatch -> ERROR; header_ok stays 0.
    - Byte 7 matches -> BODY and header_ok is set.
  - BODY: bytes 8..BLOCK_BYTES-1. After the last byte is accepted, the next cycle is DONE.
  - DONE, ERROR: hold until start. byte_valid in these states sets overflow; the byte is neither stored nor summed.
  - start in any state returns to HEADER and clears: index, sum, done, header_ok, checksum_ok, overflow, and all field registers.
- start and byte_valid in the same cycle: start wins, and that byte is taken as byte 0.
- Every accepted byte (HEADER, BODY, and the byte that caused ERROR):
  - written to RAM[index];
  - index increments;
  - sum updates as sum <= sum + byte_data, 8-bit wrap.
- checksum_ok is computed on the final byte as ((sum + byte_data) & 8'hFF) == 0 and registered together with done.
- Field capture happens on the accepting cycle, at fixed offsets as above. Fields are not updated in ERROR.
- busy = state is HEADER or BODY.
- byte_valid in IDLE is ignored and does not set overflow.
- Index never wraps inside a block; the last byte forces DONE.
- Read-back port: synchronous read; rd_data updates on the clock edge after rd_addr changes. A simultaneous write and read of the same address returns the old data.
- Latency: done rises on the clock edge that accepts byte BLOCK_BYTES-1.
- Reset mid-block: immediate abort to IDLE; nothing is retained except RAM contents.

Decomposition:
- Package edid_pkg holds:
  - state enum edid_state_t;
  - EDID_HEADER as an 8x8 constant array;
  - offset constants OFS_MFG=8, OFS_PROD=10, OFS_VER=18, OFS_EXT=126.
- Sub-module edid_byte_ram: single write port, single synchronous read port, BLOCK_BYTES x 8, no reset. This infers block RAM on the ECP5.

Test Plan:
- Valid block: start, then header, then bytes 8..9 = 10 AC, 10..11 = 34 A0, 18..19 = 01 03, 126 = 01, and byte 127 chosen so the sum is 0.
  Required: done=1, header_ok=1, checksum_ok=1, mfg_id=16'h10AC, product_code=16'hA034, edid_ver=16'h0103, ext_count=1, overflow=0.
- Same block with byte 127 incremented by 1 -> done=1, header_ok=1, checksum_ok=0.
- Header byte 3 = 0xFE -> state ERROR after byte 3; done=0, busy=0, header_ok=0. Subsequent byte_valid sets overflow=1.
- After DONE, 3 extra byte_valid strobes -> overflow=1; RAM[0] still reads 0x00 via rd_addr=0 with 1-cycle latency.
- start asserted mid-BODY (at byte 40) with byte_valid in the same cycle carrying 0x00, followed by a full valid block -> clean done=1, header_ok=1, checksum_ok=1; no residue from the aborted capture.
- rst pulsed low at byte 64 -> all outputs 0 immediately, without waiting for a clock edge. A following start plus full block completes normally.

Source files
------------

// File: rtl/edid_pkg.sv
// Shared types and constants for the EDID block checker: FSM states, the fixed
// 8-byte EDID header and the byte offsets of the identity fields.
package edid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StBody,
    StDone,
    StError
  } edid_state_t;

  // Ascending range so element 0 is the first byte on the wire.
  localparam logic [0:7][7:0] EDID_HEADER = {
    8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00
  };

  localparam int unsigned OFS_MFG  = 8;
  localparam int unsigned OFS_PROD = 10;
  localparam int unsigned OFS_VER  = 18;
  localparam int unsigned OFS_EXT  = 126;

endpackage

// File: rtl/edid_block_checker_ram.sv
// One-write, one-read block store for a captured EDID block. It has no reset and
// a registered read, so it maps onto block RAM. A read of an address being written
// in the same cycle returns the old contents.
module edid_block_checker_ram #(
  parameter int unsigned BLOCK_BYTES = 128,
  parameter int unsigned IDX_W       = $clog2(BLOCK_BYTES)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [BLOCK_BYTES];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/edid_block_checker.sv
// Captures one EDID block from the DDC byte stream. It checks the header and the
// checksum, latches the identity fields and provides a RAM read-back port.
module edid_block_checker
  import edid_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = 128,
  parameter int unsigned IDX_W       = $clog2(BLOCK_BYTES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             header_ok_o,
  output logic             checksum_ok_o,
  output logic             overflow_o,
  output logic [15:0]      mfg_id_o,
  output logic [15:0]      product_code_o,
  output logic [15:0]      edid_ver_o,
  output logic [7:0]       ext_count_o
);

  edid_state_t      state_q, cur_state;
  logic [IDX_W-1:0] idx_q, cur_idx;
  logic [7:0]       sum_q, cur_sum, sum_next;
  logic             accept, last_byte, rd_valid_q;
  logic             done_q, header_ok_q, checksum_ok_q, overflow_q;
  logic [15:0]      mfg_q, prod_q, ver_q;
  logic [7:0]       ext_q, ram_rdata;

  // A start in the same cycle as a byte makes that byte byte 0 of a fresh block.
  always_comb begin
    cur_state = start_i ? StHeader : state_q;
    cur_idx   = start_i ? '0 : idx_q;
    cur_sum   = start_i ? '0 : sum_q;
    accept    = byte_valid_i && (cur_state == StHeader || cur_state == StBody);
    sum_next  = cur_sum + byte_data_i;
    last_byte = (cur_idx == IDX_W'(BLOCK_BYTES - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      sum_q         <= '0;
      done_q        <= 1'b0;
      header_ok_q   <= 1'b0;
      checksum_ok_q <= 1'b0;
      overflow_q    <= 1'b0;
      mfg_q         <= '0;
      prod_q        <= '0;
      ver_q         <= '0;
      ext_q         <= '0;
    end else begin
      if (start_i) begin
        state_q       <= StHeader;
        idx_q         <= '0;
        sum_q         <= '0;
        done_q        <= 1'b0;
        header_ok_q   <= 1'b0;
        checksum_ok_q <= 1'b0;
        overflow_q    <= 1'b0;
        mfg_q         <= '0;
        prod_q        <= '0;
        ver_q         <= '0;
        ext_q         <= '0;
      end
      if (accept) begin
        sum_q <= sum_next;
        if (!last_byte) begin
          idx_q <= cur_idx + IDX_W'(1);
        end
        if (cur_state == StHeader) begin
          if (byte_data_i != EDID_HEADER[cur_idx[2:0]]) begin
            state_q <= StError;
          end else if (cur_idx[2:0] == 3'd7) begin
            state_q     <= StBody;
            header_ok_q <= 1'b1;
          end
        end else begin
          if (32'(cur_idx) == OFS_MFG)      mfg_q[15:8]  <= byte_data_i;
          if (32'(cur_idx) == OFS_MFG + 1)  mfg_q[7:0]   <= byte_data_i;
          if (32'(cur_idx) == OFS_PROD)     prod_q[7:0]  <= byte_data_i;
          if (32'(cur_idx) == OFS_PROD + 1) prod_q[15:8] <= byte_data_i;
          if (32'(cur_idx) == OFS_VER)      ver_q[15:8]  <= byte_data_i;
          if (32'(cur_idx) == OFS_VER + 1)  ver_q[7:0]   <= byte_data_i;
          if (32'(cur_idx) == OFS_EXT)      ext_q        <= byte_data_i;
          if (last_byte) begin
            state_q       <= StDone;
            done_q        <= 1'b1;
            checksum_ok_q <= (sum_next == 8'h00);
          end
        end
      end else if (byte_valid_i && !start_i &&
                   (state_q == StDone || state_q == StError)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // The RAM read register has no reset, so hold rd_data at 0 until it has been clocked once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b1;
    end
  end

  edid_block_checker_ram #(
    .BLOCK_BYTES(BLOCK_BYTES),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (accept),
    .waddr_i(cur_idx),
    .wdata_i(byte_data_i),
    .raddr_i(rd_addr_i),
    .rdata_o(ram_rdata)
  );

  assign rd_data_o      = rd_valid_q ? ram_rdata : 8'h00;
  assign busy_o         = (state_q == StHeader) || (state_q == StBody);
  assign done_o         = done_q;
  assign header_ok_o    = header_ok_q;
  assign checksum_ok_o  = checksum_ok_q;
  assign overflow_o     = overflow_q;
  assign mfg_id_o       = mfg_q;
  assign product_code_o = prod_q;
  assign edid_ver_o     = ver_q;
  assign ext_count_o    = ext_q;

endmodule

// File: tb/tb_edid_block_checker.sv
// Scoreboard bench for edid_block_checker: expected block results are queued when
// a block is driven and compared when the checker finishes the block.
module tb_edid_block_checker;

  localparam int unsigned BB = 128;
  localparam int unsigned IW = $clog2(BB);

  logic          clk = 1'b0;
  logic          rst_n, start, bv;
  logic [7:0]    bd;
  logic [IW-1:0] ra;
  logic [7:0]    rd_data, ext_count;
  logic          busy, done, header_ok, checksum_ok, overflow;
  logic [15:0]   mfg_id, product_code, edid_ver;

  always #5 clk = ~clk;

  edid_block_checker #(
    .BLOCK_BYTES(BB),
    .IDX_W      (IW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .byte_valid_i  (bv),
    .byte_data_i   (bd),
    .rd_addr_i     (ra),
    .rd_data_o     (rd_data),
    .busy_o        (busy),
    .done_o        (done),
    .header_ok_o   (header_ok),
    .checksum_ok_o (checksum_ok),
    .overflow_o    (overflow),
    .mfg_id_o      (mfg_id),
    .product_code_o(product_code),
    .edid_ver_o    (edid_ver),
    .ext_count_o   (ext_count)
  );

  typedef struct packed {
    logic        done;
    logic        header_ok;
    logic        checksum_ok;
    logic        overflow;
    logic [15:0] mfg;
    logic [15:0] prod;
    logic [15:0] ver;
    logic [7:0]  ext;
  } res_t;

  res_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  blk [BB];
  logic [63:0] hdr_w    = 64'h00FF_FFFF_FFFF_FF00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Valid block with the identity fields of the test plan and a zero checksum.
  task automatic build_block(input int seed);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < int'(BB); i++) blk[i] = 8'(i * seed + 3);
    for (int i = 0; i < 8; i++) blk[i] = hdr_w[63 - 8 * i -: 8];
    blk[8]   = 8'h10;
    blk[9]   = 8'hAC;
    blk[10]  = 8'h34;
    blk[11]  = 8'hA0;
    blk[18]  = 8'h01;
    blk[19]  = 8'h03;
    blk[126] = 8'h01;
    for (int i = 0; i < int'(BB) - 1; i++) s = s + blk[i];
    blk[BB-1] = 8'h00 - s;
  endtask

  function automatic res_t model();
    res_t       r;
    logic [7:0] s;
    r = '0;
    s = 8'h00;
    r.header_ok = 1'b1;
    for (int i = 0; i < 8; i++) if (blk[i] != hdr_w[63 - 8 * i -: 8]) r.header_ok = 1'b0;
    for (int i = 0; i < int'(BB); i++) s = s + blk[i];
    r.done        = 1'b1;
    r.checksum_ok = (s == 8'h00);
    r.mfg         = {blk[8], blk[9]};
    r.prod        = {blk[11], blk[10]};
    r.ver         = {blk[18], blk[19]};
    r.ext         = blk[126];
    return r;
  endfunction

  task automatic put(input logic [7:0] d, input logic st);
    start = st;
    bv    = 1'b1;
    bd    = d;
    @(negedge clk);
    start = 1'b0;
    bv    = 1'b0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_bytes(input int first, input int last);
    for (int i = first; i <= last; i++) put(blk[i], 1'b0);
  endtask

  task automatic finish_block(input string name);
    res_t e;
    int   n;
    n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, ".done_in_time"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      check({name, ".queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({name, ".done"},        32'(done),        32'(e.done));
    check({name, ".busy"},        32'(busy),        32'd0);
    check({name, ".header_ok"},   32'(header_ok),   32'(e.header_ok));
    check({name, ".checksum_ok"}, 32'(checksum_ok), 32'(e.checksum_ok));
    check({name, ".overflow"},    32'(overflow),    32'(e.overflow));
    check({name, ".mfg_id"},      32'(mfg_id),      32'(e.mfg));
    check({name, ".product"},     32'(product_code), 32'(e.prod));
    check({name, ".edid_ver"},    32'(edid_ver),    32'(e.ver));
    check({name, ".ext_count"},   32'(ext_count),   32'(e.ext));
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".busy"},        32'(busy),         32'd0);
    check({name, ".done"},        32'(done),         32'd0);
    check({name, ".header_ok"},   32'(header_ok),    32'd0);
    check({name, ".checksum_ok"}, 32'(checksum_ok),  32'd0);
    check({name, ".overflow"},    32'(overflow),     32'd0);
    check({name, ".mfg_id"},      32'(mfg_id),       32'd0);
    check({name, ".product"},     32'(product_code), 32'd0);
    check({name, ".edid_ver"},    32'(edid_ver),     32'd0);
    check({name, ".ext_count"},   32'(ext_count),    32'd0);
    check({name, ".rd_data"},     32'(rd_data),      32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    bv    = 1'b0;
    bd    = 8'h00;
    ra    = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte strobes in IDLE are ignored.
    put(8'h12, 1'b0);
    check("idle.overflow", 32'(overflow), 32'd0);
    check("idle.busy",     32'(busy),     32'd0);

    // Valid block.
    build_block(7);
    exp_q.push_back(model());
    pulse_start();
    check("valid.busy_after_start", 32'(busy), 32'd1);
    run_bytes(0, BB - 1);
    finish_block("valid");

    // Bad checksum.
    build_block(7);
    blk[BB-1] = blk[BB-1] + 8'h01;
    exp_q.push_back(model());
    pulse_start();
    run_bytes(0, BB - 1);
    finish_block("badsum");

    // Header mismatch at byte 3.
    build_block(5);
    blk[3] = 8'hFE;
    pulse_start();
    run_bytes(0, 3);
    check("hdrerr.busy",      32'(busy),      32'd0);
    check("hdrerr.done",      32'(done),      32'd0);
    check("hdrerr.header_ok", 32'(header_ok), 32'd0);
    check("hdrerr.overflow",  32'(overflow),  32'd0);
    put(8'h55, 1'b0);
    check("hdrerr.overflow_set", 32'(overflow), 32'd1);

    // Overflow after DONE and read-back.
    build_block(7);
    exp_q.push_back(model());
    pulse_start();
    run_bytes(0, BB - 1);
    finish_block("ovf");
    for (int i = 0; i < 3; i++) put(8'h5A, 1'b0);
    check("ovf.overflow", 32'(overflow), 32'd1);
    check("ovf.done_held", 32'(done), 32'd1);
    ra = '0;
    @(negedge clk);
    check("rd.addr0", 32'(rd_data), 32'h00);
    ra = IW'(8);
    #1 check("rd.latency_old", 32'(rd_data), 32'h00);
    @(negedge clk);
    check("rd.addr8", 32'(rd_data), 32'h10);
    ra = IW'(BB - 1);
    @(negedge clk);
    check("rd.last_unchanged", 32'(rd_data), 32'(blk[BB-1]));

    // Restart mid-body together with a 0x00 byte taken as byte 0.
    build_block(11);
    blk[8]   = 8'h77;
    blk[126] = 8'h05;
    pulse_start();
    run_bytes(0, 39);
    check("abort.busy", 32'(busy), 32'd1);
    build_block(7);
    exp_q.push_back(model());
    put(blk[0], 1'b1);
    check("abort.restart_busy", 32'(busy), 32'd1);
    run_bytes(1, BB - 1);
    finish_block("restart");

    // Asynchronous reset mid-block.
    build_block(9);
    pulse_start();
    run_bytes(0, 63);
    check("midrst.mfg_before", 32'(mfg_id), 32'h10AC);
    rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_block(7);
    exp_q.push_back(model());
    pulse_start();
    run_bytes(0, BB - 1);
    finish_block("after_rst");

    check("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
